shift_arb_ctrl: RTL and testbench

Controller and arbiter for a shared parallel-in/serial-out shift register. Two requesters each present a parallel word. The block grants one requester round-robin, loads its word into the internal shift register, and sequences WIDTH shift cycles MSB-first onto serial_out with a framing strobe. It sits between word-level producers and a single-bit serial link, and is the sole owner of the shift register.

---
 rtl/shift_arb_ctrl_if.sv | 45 ++++
 rtl/shift_arb_ctrl.sv | 121 ++++++++++++
 tb/tb_shift_arb_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_arb_ctrl_if
// Description : Bundle of the requester handshake and serial-link signals of
//               shift_arb_ctrl.
//               master : requester/link side (drives req/data, observes rest)
//               slave  : controller side (observes req/data, drives rest)
//   req0/req1     requester requests, held until the matching ack
//   data0/data1   requester words, sampled only at the acceptance edge
//   ack0/ack1     one-cycle acceptance pulses
//   gnt           one-hot current owner, 0 when idle
//   shift_reg     shift register contents
//   serial_out    serial data, MSB first, 0 outside a frame
//   shift_valid   high for the WIDTH bit cycles of a frame
//   done          one-cycle pulse after the last bit
//   busy          high while a frame is shifting or completing
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_arb_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             ack0;
  logic             ack1;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] shift_reg;
  logic             serial_out;
  logic             shift_valid;
  logic             done;
  logic             busy;

  modport master (
    output req0, data0, req1, data1,
    input  ack0, ack1, gnt, shift_reg, serial_out, shift_valid, done, busy
  );

  modport slave (
    input  req0, data0, req1, data1,
    output ack0, ack1, gnt, shift_reg, serial_out, shift_valid, done, busy
  );
endinterface
`default_nettype wire

// File: rtl/shift_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_arb_ctrl
// Description : Round-robin arbiter and sequencer for a shared parallel-in /
//               serial-out shift register. Accepts one requester word in
//               IDLE, shifts it out MSB first over WIDTH cycles, then spends
//               one DONE cycle before returning to IDLE.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - shift_arb_ctrl_if slave modport (requests, words,
//                      acks, grant, shift register and serial link)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arb_ctrl #(
  parameter int WIDTH = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  shift_arb_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_shift_reg;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [1:0]        r_gnt;
  logic              r_last_served;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_shift_valid;
  logic              r_done;
  logic              r_busy;

  logic              w_req_any;
  logic              w_pick1;

  // Requester 1 wins when it is alone, or when both request and requester 0
  // was the last one served.
  assign w_req_any = bus.req0 | bus.req1;
  assign w_pick1   = bus.req1 & (~bus.req0 | ~r_last_served);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_shift_reg   <= '0;
      r_bit_cnt     <= '0;
      r_gnt         <= 2'b00;
      r_last_served <= 1'b1;   // requester 0 wins the first contention
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_shift_valid <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      // Pulse outputs default low; they are raised for a single cycle below.
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_shift_reg   <= w_pick1 ? bus.data1 : bus.data0;
            r_gnt         <= w_pick1 ? 2'b10 : 2'b01;
            r_ack0        <= ~w_pick1;
            r_ack1        <= w_pick1;
            r_last_served <= w_pick1;
            r_bit_cnt     <= '0;
            r_shift_valid <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          r_shift_reg <= {r_shift_reg[WIDTH-2:0], 1'b0};
          r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == C_LAST_BIT) begin
            r_shift_valid <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_gnt         <= 2'b00;
          r_shift_valid <= 1'b0;
          r_busy        <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  // serial_out is decoded from state so an asynchronous reset silences the
  // link immediately, without waiting for a clock edge.
  assign bus.serial_out  = (r_state == ST_SHIFT) & r_shift_reg[WIDTH-1];
  assign bus.shift_reg   = r_shift_reg;
  assign bus.gnt         = r_gnt;
  assign bus.ack0        = r_ack0;
  assign bus.ack1        = r_ack1;
  assign bus.shift_valid = r_shift_valid;
  assign bus.done        = r_done;
  assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_shift_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_arb_ctrl
// Description : Directed self-checking bench for shift_arb_ctrl. Covers
//               reset, a single frame, contention, a lone requester, requests
//               arriving while busy, mid-frame reset and an 8-bit instance.
// Ports       : none (top-level bench)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_arb_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  shift_arb_ctrl_if #(.WIDTH(4)) bus ();
  shift_arb_ctrl_if #(.WIDTH(8)) bus8 ();

  shift_arb_ctrl #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  shift_arb_ctrl #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  // Packed status: {ack1, ack0, gnt[1:0], serial_out, shift_valid, done, busy}
  wire [7:0] st4 = {bus.ack1, bus.ack0, bus.gnt, bus.serial_out,
                    bus.shift_valid, bus.done, bus.busy};
  wire [7:0] st8 = {bus8.ack1, bus8.ack0, bus8.gnt, bus8.serial_out,
                    bus8.shift_valid, bus8.done, bus8.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: leaves both DUTs in IDLE at a falling edge with rst low.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus8.req0 = 1'b0; bus8.req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (st4 !== 8'h00) begin
      failures++;
      $display("FAIL reset_status: got %b expected %b", st4, 8'h00);
    end
    checks++;
    if (bus.shift_reg !== 4'h0) begin
      failures++;
      $display("FAIL reset_shift_reg: got %b expected %b", bus.shift_reg, 4'h0);
    end
    checks++;
    if (st8 !== 8'h00) begin
      failures++;
      $display("FAIL reset_status_w8: got %b expected %b", st8, 8'h00);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [3:0] exp_sr [5];
    logic [7:0] exp;
    logic [3:0] word;
    exp_sr = '{4'b1011, 4'b0110, 4'b1100, 4'b1000, 4'b0000};
    word = 4'b1011;
    apply_reset();
    bus.req0 = 1'b1; bus.data0 = word;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp = {1'b0, (k == 0), (k < 5) ? 2'b01 : 2'b00,
             (k < 4) ? word[3-k] : 1'b0, (k < 4), (k == 4), (k < 5)};
      checks++;
      if (st4 !== exp) begin
        failures++;
        $display("FAIL single_status k%0d: got %b expected %b", k, st4, exp);
      end
      if (k < 5) begin
        checks++;
        if (bus.shift_reg !== exp_sr[k]) begin
          failures++;
          $display("FAIL single_shift_reg k%0d: got %b expected %b", k, bus.shift_reg, exp_sr[k]);
        end
      end
      if (k == 0) bus.req0 = 1'b0;
    end
  endtask

  task automatic test_contention();
    logic [3:0] words [3];
    logic       owner [3];
    logic [3:0] w;
    logic [7:0] exp;
    words = '{4'b1011, 4'b0110, 4'b1011};
    owner = '{1'b0, 1'b1, 1'b0};
    apply_reset();
    bus.req0 = 1'b1; bus.data0 = 4'b1011;
    bus.req1 = 1'b1; bus.data1 = 4'b0110;
    for (int f = 0; f < 3; f++) begin
      w = words[f];
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        exp = {(k == 0) && owner[f], (k == 0) && !owner[f],
               (k < 5) ? (owner[f] ? 2'b10 : 2'b01) : 2'b00,
               (k < 4) ? w[3-k] : 1'b0, (k < 4), (k == 4), (k < 5)};
        checks++;
        if (st4 !== exp) begin
          failures++;
          $display("FAIL contention_status f%0d k%0d: got %b expected %b", f, k, st4, exp);
        end
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic test_lone_requester();
    logic [3:0] w;
    logic [7:0] exp;
    w = 4'b1001;
    apply_reset();
    bus.req1 = 1'b1; bus.data1 = w;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        exp = {(k == 0), 1'b0, (k < 5) ? 2'b10 : 2'b00,
               (k < 4) ? w[3-k] : 1'b0, (k < 4), (k == 4), (k < 5)};
        checks++;
        if (st4 !== exp) begin
          failures++;
          $display("FAIL lone_status f%0d k%0d: got %b expected %b", f, k, st4, exp);
        end
      end
    end
    bus.req1 = 1'b0;
  endtask

  task automatic test_busy_blocking();
    logic [3:0] words [2];
    logic       owner [2];
    logic [3:0] w;
    logic [7:0] exp;
    words = '{4'b1011, 4'b0110};
    owner = '{1'b0, 1'b1};
    apply_reset();
    bus.req0 = 1'b1; bus.data0 = 4'b1011;
    for (int f = 0; f < 2; f++) begin
      w = words[f];
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        exp = {(k == 0) && owner[f], (k == 0) && !owner[f],
               (k < 5) ? (owner[f] ? 2'b10 : 2'b01) : 2'b00,
               (k < 4) ? w[3-k] : 1'b0, (k < 4), (k == 4), (k < 5)};
        checks++;
        if (st4 !== exp) begin
          failures++;
          $display("FAIL busy_status f%0d k%0d: got %b expected %b", f, k, st4, exp);
        end
        if (f == 0 && k == 0) begin
          bus.req0 = 1'b0; bus.data0 = 4'b0000;
        end
        if (f == 0 && k == 1) begin
          bus.req1 = 1'b1; bus.data1 = 4'b0110;
        end
        if (f == 1 && k == 0) bus.req1 = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp;
    apply_reset();
    bus.req0 = 1'b1; bus.data0 = 4'b1101;
    @(negedge clk);
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.serial_out, bus.shift_valid} !== 2'b11) begin
      failures++;
      $display("FAIL midrst_second_bit: got %b expected %b", {bus.serial_out, bus.shift_valid}, 2'b11);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (st4 !== 8'h00) begin
      failures++;
      $display("FAIL midrst_status: got %b expected %b", st4, 8'h00);
    end
    checks++;
    if (bus.shift_reg !== 4'h0) begin
      failures++;
      $display("FAIL midrst_shift_reg: got %b expected %b", bus.shift_reg, 4'h0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.req0 = 1'b1; bus.data0 = 4'b1011;
    bus.req1 = 1'b1; bus.data1 = 4'b0110;
    @(negedge clk);
    exp = {1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1};
    checks++;
    if (st4 !== exp) begin
      failures++;
      $display("FAIL midrst_first_winner: got %b expected %b", st4, exp);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_width8();
    logic [7:0] w;
    logic [7:0] exp;
    int         valid_cycles;
    w = 8'hA5;
    valid_cycles = 0;
    apply_reset();
    bus8.req0 = 1'b1; bus8.data0 = w;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus8.shift_valid === 1'b1) valid_cycles++;
      exp = {1'b0, (k == 0), (k < 9) ? 2'b01 : 2'b00,
             (k < 8) ? w[7-k] : 1'b0, (k < 8), (k == 8), (k < 9)};
      checks++;
      if (st8 !== exp) begin
        failures++;
        $display("FAIL w8_status k%0d: got %b expected %b", k, st8, exp);
      end
      if (k == 0) bus8.req0 = 1'b0;
    end
    checks++;
    if (valid_cycles != 8) begin
      failures++;
      $display("FAIL w8_valid_count: got %0d expected %0d", valid_cycles, 8);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.data0 = '0; bus.req1 = 1'b0; bus.data1 = '0;
    bus8.req0 = 1'b0; bus8.data0 = '0; bus8.req1 = 1'b0; bus8.data1 = '0;
    test_reset();
    test_single_frame();
    test_contention();
    test_lone_requester();
    test_busy_blocking();
    test_reset_midframe();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
